// File: rtl/mem_lsu_pkg.sv
// Shared constants, funct3 codes and FSM state type for the RV64 load/store unit.
package mem_lsu_pkg;

  localparam int          REG_BUS   = 64;
  localparam logic [63:0] ZERO_WORD = 64'h0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte strobes for an access of size 2**sz bytes, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane alignment: store strobe/data shifting and load shift plus sign/zero extension.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN   = REG_BUS,
  parameter int MASK_W = XLEN / 8
) (
  input  logic [2:0]        st_funct3,
  input  logic [2:0]        st_offset,
  input  logic [XLEN-1:0]   st_data,
  output logic [MASK_W-1:0] st_mask,
  output logic [XLEN-1:0]   st_data_sh,
  input  logic [2:0]        ld_funct3,
  input  logic [2:0]        ld_offset,
  input  logic [XLEN-1:0]   ld_raw,
  output logic [XLEN-1:0]   ld_data
);

  logic [MASK_W-1:0] mask_base;
  logic [XLEN-1:0]   ld_shifted;

  always_comb begin
    mask_base  = MASK_W'(size_mask(st_funct3[1:0]));
    // Lanes shifted past byte 7 simply fall off the top.
    st_mask    = mask_base << st_offset;
    st_data_sh = st_data << {st_offset, 3'b000};
    ld_shifted = ld_raw >> {ld_offset, 3'b000};
    case (ld_funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LH:   ld_data = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LW:   ld_data = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      F3_LWU:  ld_data = {{(XLEN-32){1'b0}}, ld_shifted[31:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: one load/store at a time over a req/ack data bus.
// Define MEM_MISALIGN_CHK_EN to reject misaligned halfword/word/dword accesses without a bus request.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN   = REG_BUS,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_ld,
  input  logic              mem_st,
  input  logic [2:0]        mem_funct3,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [MASK_W-1:0] dbus_wmask,
  input  logic [XLEN-1:0]   dbus_rdata,
  input  logic              dbus_ack,
  output logic [XLEN-1:0]   mem_r_data,
  output logic              rd_data_mem_ena,
  output logic              mem_done,
  output logic              mem_misalign
);

  state_t            state_reg, state_next;
  logic [2:0]        offset_reg;
  logic [2:0]        funct3_reg;
  logic              load_reg;
  logic              we_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [MASK_W-1:0] wmask_reg;
  logic [XLEN-1:0]   r_data_reg;

  logic              accept;
  logic              illegal;
  logic              misalign;
  logic              reject;
  logic [MASK_W-1:0] st_mask;
  logic [XLEN-1:0]   st_data_sh;
  logic [XLEN-1:0]   ld_data;

  lsu_align #(.XLEN(XLEN), .MASK_W(MASK_W)) u_align (
    .st_funct3  (mem_funct3),
    .st_offset  (mem_addr[2:0]),
    .st_data    (mem_wdata),
    .st_mask    (st_mask),
    .st_data_sh (st_data_sh),
    .ld_funct3  (funct3_reg),
    .ld_offset  (offset_reg),
    .ld_raw     (dbus_rdata),
    .ld_data    (ld_data)
  );

  assign accept  = (state_reg == IDLE) && in_valid && (mem_ld || mem_st);
  assign illegal = (mem_ld && mem_st) || (mem_ld && mem_funct3 == 3'b111) ||
                   (mem_st && mem_funct3[2]);

`ifdef MEM_MISALIGN_CHK_EN
  logic misalign_reg;

  always_comb begin
    case (mem_funct3[1:0])
      2'b01:   misalign = mem_addr[0];
      2'b10:   misalign = |mem_addr[1:0];
      2'b11:   misalign = |mem_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      misalign_reg <= 1'b0;
    else if (accept)
      misalign_reg <= misalign && !illegal;
  end

  assign mem_misalign = (state_reg == RESP) && misalign_reg;
`else
  assign misalign     = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  assign reject = illegal || misalign;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = reject ? RESP : BUSY;
      BUSY:    if (dbus_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      offset_reg <= 3'b000;
      funct3_reg <= 3'b000;
      load_reg   <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wmask_reg  <= '0;
      r_data_reg <= ZERO_WORD;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        offset_reg <= mem_addr[2:0];
        funct3_reg <= mem_funct3;
        load_reg   <= mem_ld && !reject;
        we_reg     <= mem_st && !reject;
        addr_reg   <= {mem_addr[XLEN-1:3], 3'b000};
        wdata_reg  <= st_data_sh;
        wmask_reg  <= mem_st ? st_mask : '0;
        if (reject)
          r_data_reg <= ZERO_WORD;
      end
      // Result register only changes on entry to RESP, so it holds between accesses.
      if (state_reg == BUSY && dbus_ack)
        r_data_reg <= load_reg ? ld_data : ZERO_WORD;
    end
  end

  assign in_ready        = (state_reg == IDLE);
  assign dbus_req        = (state_reg == BUSY);
  assign dbus_we         = we_reg;
  assign dbus_addr       = addr_reg;
  assign dbus_wdata      = wdata_reg;
  assign dbus_wmask      = wmask_reg;
  assign mem_r_data      = r_data_reg;
  assign mem_done        = (state_reg == RESP);
  assign rd_data_mem_ena = (state_reg == RESP) && load_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu; outputs sampled on the falling edge.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_ld = 1'b0;
  logic        mem_st = 1'b0;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [63:0] mem_addr = 64'h0;
  logic [63:0] mem_wdata = 64'h0;
  logic        dbus_req;
  logic        dbus_we;
  logic [63:0] dbus_addr;
  logic [63:0] dbus_wdata;
  logic [7:0]  dbus_wmask;
  logic [63:0] dbus_rdata = 64'h0;
  logic        dbus_ack = 1'b0;
  logic [63:0] mem_r_data;
  logic        rd_data_mem_ena;
  logic        mem_done;
  logic        mem_misalign;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .mem_ld          (mem_ld),
    .mem_st          (mem_st),
    .mem_funct3      (mem_funct3),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .dbus_req        (dbus_req),
    .dbus_we         (dbus_we),
    .dbus_addr       (dbus_addr),
    .dbus_wdata      (dbus_wdata),
    .dbus_wmask      (dbus_wmask),
    .dbus_rdata      (dbus_rdata),
    .dbus_ack        (dbus_ack),
    .mem_r_data      (mem_r_data),
    .rd_data_mem_ena (rd_data_mem_ena),
    .mem_done        (mem_done),
    .mem_misalign    (mem_misalign)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one access in IDLE; returns at the falling edge after the accept edge.
  task automatic start(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    in_valid = 1'b1; mem_ld = ld; mem_st = st; mem_funct3 = f3;
    mem_addr = addr; mem_wdata = wdata;
    @(posedge clk);
    #1;
    in_valid = 1'b0; mem_ld = 1'b0; mem_st = 1'b0;
    @(negedge clk);
    $display("access ld=%0b st=%0b f3=%0d addr=%h wdata=%h", ld, st, f3, addr, wdata);
  endtask

  // Ack after extra wait cycles; returns at the falling edge of the RESP cycle.
  task automatic finish(input int extra, input logic [63:0] rdata);
    repeat (extra) @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = rdata;
    @(posedge clk);
    #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    $display("  resp done=%0b ena=%0b r_data=%h", mem_done, rd_data_mem_ena, mem_r_data);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_req", 64'(dbus_req), 64'd0);
    chk("reset_done", 64'(mem_done), 64'd0);
    chk("reset_r_data", mem_r_data, 64'h0);
    rst = 1'b1;

    // SD, ack two cycles after req rises
    start(1'b0, 1'b1, 3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788);
    chk("sd_req", 64'(dbus_req), 64'd1);
    chk("sd_in_ready", 64'(in_ready), 64'd0);
    chk("sd_we", 64'(dbus_we), 64'd1);
    chk("sd_addr", dbus_addr, 64'h8000_0010);
    chk("sd_wmask", 64'(dbus_wmask), 64'hFF);
    chk("sd_wdata", dbus_wdata, 64'h1122_3344_5566_7788);
    @(negedge clk);
    chk("sd_req_held", 64'(dbus_req), 64'd1);
    chk("sd_addr_held", dbus_addr, 64'h8000_0010);
    finish(0, 64'h0);
    chk("sd_done", 64'(mem_done), 64'd1);
    chk("sd_ena", 64'(rd_data_mem_ena), 64'd0);
    chk("sd_req_drop", 64'(dbus_req), 64'd0);
    @(negedge clk);
    chk("sd_done_pulse", 64'(mem_done), 64'd0);

    // LB minimum latency, then LBU
    start(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'h0);
    chk("lb_req", 64'(dbus_req), 64'd1);
    chk("lb_we", 64'(dbus_we), 64'd0);
    chk("lb_addr", dbus_addr, 64'h8000_0000);
    finish(0, 64'h0000_0000_8000_0000);
    chk("lb_done", 64'(mem_done), 64'd1);
    chk("lb_ena", 64'(rd_data_mem_ena), 64'd1);
    chk("lb_data", mem_r_data, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    chk("lb_ena_pulse", 64'(rd_data_mem_ena), 64'd0);
    chk("lb_data_hold", mem_r_data, 64'hFFFF_FFFF_FFFF_FF80);
    start(1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'h0);
    finish(0, 64'h0000_0000_8000_0000);
    chk("lbu_ena", 64'(rd_data_mem_ena), 64'd1);
    chk("lbu_data", mem_r_data, 64'h0000_0000_0000_0080);

    // SH into the top halfword
    start(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD);
    chk("sh_addr", dbus_addr, 64'h8000_0000);
    chk("sh_wmask", 64'(dbus_wmask), 64'hC0);
    chk("sh_wdata", dbus_wdata, 64'hABCD_0000_0000_0000);
    finish(1, 64'h0);
    chk("sh_done", 64'(mem_done), 64'd1);
    chk("sh_r_data_zero", mem_r_data, 64'h0);

    // LW / LWU from the upper word
    start(1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'h0);
    finish(0, 64'h8765_4321_0000_0000);
    chk("lw_data", mem_r_data, 64'hFFFF_FFFF_8765_4321);
    start(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'h0);
    finish(0, 64'h8765_4321_0000_0000);
    chk("lwu_data", mem_r_data, 64'h0000_0000_8765_4321);
    chk("lwu_ena", 64'(rd_data_mem_ena), 64'd1);

    // Illegal load funct3 goes straight to RESP without a bus request
    start(1'b1, 1'b0, 3'b111, 64'h8000_0008, 64'h0);
    chk("ill_req", 64'(dbus_req), 64'd0);
    chk("ill_done", 64'(mem_done), 64'd1);
    chk("ill_ena", 64'(rd_data_mem_ena), 64'd0);
    chk("ill_r_data", mem_r_data, 64'h0);

    // Reset in BUSY, then a late ack
    start(1'b1, 1'b0, 3'b011, 64'h8000_0018, 64'h0);
    finish(0, 64'hDEAD_BEEF_0123_4567);
    chk("ld_data", mem_r_data, 64'hDEAD_BEEF_0123_4567);
    start(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'h0);
    chk("rst_busy_req", 64'(dbus_req), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    $display("reset asserted during BUSY");
    chk("rst_req_low", 64'(dbus_req), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    finish(0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("late_ack_done", 64'(mem_done), 64'd0);
    chk("late_ack_r_data", mem_r_data, 64'h0);
    chk("late_ack_in_ready", 64'(in_ready), 64'd1);
    chk("late_ack_req", 64'(dbus_req), 64'd0);

    // Misaligned word access
    start(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'h0);
`ifdef MEM_MISALIGN_CHK_EN
    chk("mis_req", 64'(dbus_req), 64'd0);
    chk("mis_flag", 64'(mem_misalign), 64'd1);
    chk("mis_done", 64'(mem_done), 64'd1);
    chk("mis_ena", 64'(rd_data_mem_ena), 64'd0);
    @(negedge clk);
    chk("mis_flag_pulse", 64'(mem_misalign), 64'd0);
`else
    chk("mis_req", 64'(dbus_req), 64'd1);
    chk("mis_addr", dbus_addr, 64'h8000_0000);
    finish(0, 64'h0000_1234_5678_0000);
    chk("mis_flag", 64'(mem_misalign), 64'd0);
    chk("mis_data", mem_r_data, 64'h0000_0000_1234_5678);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
